mem_interpreter: RTL and testbench

Registered decoder that turns the 2-bit `memoryena` mode request into enable/write-enable strobes for two memory blocks and the serializer/deserializer, plus a per-mode access address. It sits between the top-level control FSM and the two block RAMs. The deserializer fills block 1 or block 2, and the serializer drains whichever block was filled most recently (ping-pong buffering).

---
 rtl/mem_interpreter.sv | 163 ++++++++++++++++
 tb/tb_mem_interpreter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_interpreter.sv
// -----------------------------------------------------------------------------
// mem_interpreter
//
// Purpose:
//   Registered decoder between the top-level control FSM and two block RAMs.
//   The 2-bit mode request selects idle, fill block 1, fill block 2 or drain.
//   The decoder turns that request into port/write enables for the two blocks
//   and run enables for the serializer/deserializer. It also produces a
//   per-mode word address. Filling alternates between blocks (ping-pong), and
//   a drain always reads the block that was filled most recently.
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   reset      in   synchronous active-high reset, highest priority
//   memoryena  in   [1:0] mode request: 00 idle, 01 fill 1, 10 fill 2, 11 drain
//   block1ena  out  block 1 port enable
//   block1wea  out  block 1 write enable
//   block2ena  out  block 2 port enable
//   block2wea  out  block 2 write enable
//   seriena    out  serializer enable (drain active)
//   deseriena  out  deserializer enable (fill active)
//   addr       out  [ADDR_WIDTH-1:0] word address for the active block
//   done       out  one-cycle pulse when addr wraps while a mode is held
//
// Handshake:
//   There is no valid/ready pair. The requester holds memoryena for as many
//   cycles as it needs. Every output reflects the request sampled on the
//   previous rising edge, giving one cycle of latency.
// -----------------------------------------------------------------------------
module mem_interpreter #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            memoryena,
   output logic                  block1ena,
   output logic                  block1wea,
   output logic                  block2ena,
   output logic                  block2wea,
   output logic                  seriena,
   output logic                  deseriena,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  done
);

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'b00,
      MODE_FILL1 = 2'b01,
      MODE_FILL2 = 2'b10,
      MODE_DRAIN = 2'b11
   } mode_t;

   // State registers
   mode_t                 r_mode_q;
   logic                  r_last_sel;    // 0: block 1 filled last, 1: block 2
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_done;
   logic                  r_block1ena;
   logic                  r_block1wea;
   logic                  r_block2ena;
   logic                  r_block2wea;
   logic                  r_seriena;
   logic                  r_deseriena;

   // Next-state values
   mode_t                 w_mode_d;
   logic                  w_mode_change;
   logic                  w_last_sel_d;
   logic [ADDR_WIDTH-1:0] w_addr_d;
   logic                  w_done_d;
   logic                  w_block1ena_d;
   logic                  w_block1wea_d;
   logic                  w_block2ena_d;
   logic                  w_block2wea_d;
   logic                  w_seriena_d;
   logic                  w_deseriena_d;

   always_comb begin
      w_mode_d      = mode_t'(memoryena);
      w_mode_change = (w_mode_d != r_mode_q);
      w_last_sel_d  = r_last_sel;
      w_addr_d      = '0;
      w_done_d      = 1'b0;
      w_block1ena_d = 1'b0;
      w_block1wea_d = 1'b0;
      w_block2ena_d = 1'b0;
      w_block2wea_d = 1'b0;
      w_seriena_d   = 1'b0;
      w_deseriena_d = 1'b0;

      // A fill is recorded as "last filled" on the edge where it ends. The
      // drain decode below uses this next-state value so that a direct
      // fill->drain transition already reads the block that was just filled.
      if ((r_mode_q == MODE_FILL1) && (w_mode_d != MODE_FILL1)) begin
         w_last_sel_d = 1'b0;
      end else if ((r_mode_q == MODE_FILL2) && (w_mode_d != MODE_FILL2)) begin
         w_last_sel_d = 1'b1;
      end

      // The address restarts on every mode change and counts while a
      // non-idle mode is held. done is raised only on a wrap in a held mode.
      if (!w_mode_change && (w_mode_d != MODE_IDLE)) begin
         w_addr_d = r_addr + ADDR_WIDTH'(1);
         w_done_d = (r_addr == '1);
      end

      case (w_mode_d)
         MODE_FILL1: begin
            w_block1ena_d = 1'b1;
            w_block1wea_d = 1'b1;
            w_deseriena_d = 1'b1;
         end
         MODE_FILL2: begin
            w_block2ena_d = 1'b1;
            w_block2wea_d = 1'b1;
            w_deseriena_d = 1'b1;
         end
         MODE_DRAIN: begin
            w_seriena_d   = 1'b1;
            w_block1ena_d = ~w_last_sel_d;
            w_block2ena_d = w_last_sel_d;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode_q    <= MODE_IDLE;
         r_last_sel  <= 1'b0;
         r_addr      <= '0;
         r_done      <= 1'b0;
         r_block1ena <= 1'b0;
         r_block1wea <= 1'b0;
         r_block2ena <= 1'b0;
         r_block2wea <= 1'b0;
         r_seriena   <= 1'b0;
         r_deseriena <= 1'b0;
      end else begin
         r_mode_q    <= w_mode_d;
         r_last_sel  <= w_last_sel_d;
         r_addr      <= w_addr_d;
         r_done      <= w_done_d;
         r_block1ena <= w_block1ena_d;
         r_block1wea <= w_block1wea_d;
         r_block2ena <= w_block2ena_d;
         r_block2wea <= w_block2wea_d;
         r_seriena   <= w_seriena_d;
         r_deseriena <= w_deseriena_d;
      end
   end

   assign block1ena = r_block1ena;
   assign block1wea = r_block1wea;
   assign block2ena = r_block2ena;
   assign block2wea = r_block2wea;
   assign seriena   = r_seriena;
   assign deseriena = r_deseriena;
   assign addr      = r_addr;
   assign done      = r_done;

endmodule

// File: tb/tb_mem_interpreter.sv
// -----------------------------------------------------------------------------
// tb_mem_interpreter
//
// Directed bench for mem_interpreter. There are two instances on the same
// stimulus: a narrow one (ADDR_WIDTH = 2) that exercises the address wrap,
// and one at the default width. Enable outputs are compared as a packed
// vector {block1ena, block1wea, block2ena, block2wea, seriena, deseriena}.
// -----------------------------------------------------------------------------
module tb_mem_interpreter;

   logic       clk;
   logic       reset;
   logic [1:0] memoryena;

   // Narrow instance (ADDR_WIDTH = 2)
   logic       block1ena, block1wea, block2ena, block2wea, seriena, deseriena;
   logic [1:0] addr;
   logic       done;

   // Default-width instance
   logic       d_block1ena, d_block1wea, d_block2ena, d_block2wea;
   logic       d_seriena, d_deseriena;
   logic [9:0] d_addr;
   logic       d_done;

   logic [5:0] en;
   logic [5:0] d_en;

   int tests_run;
   int tests_failed;

   assign en   = {block1ena, block1wea, block2ena, block2wea, seriena, deseriena};
   assign d_en = {d_block1ena, d_block1wea, d_block2ena, d_block2wea, d_seriena, d_deseriena};

   localparam logic [5:0] EN_IDLE  = 6'b000000;
   localparam logic [5:0] EN_FILL1 = 6'b110001;
   localparam logic [5:0] EN_FILL2 = 6'b001101;
   localparam logic [5:0] EN_DRN1  = 6'b100010;
   localparam logic [5:0] EN_DRN2  = 6'b001010;

   mem_interpreter #(.ADDR_WIDTH(2)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .memoryena (memoryena),
      .block1ena (block1ena),
      .block1wea (block1wea),
      .block2ena (block2ena),
      .block2wea (block2wea),
      .seriena   (seriena),
      .deseriena (deseriena),
      .addr      (addr),
      .done      (done)
   );

   mem_interpreter u_dut_wide (
      .clk       (clk),
      .reset     (reset),
      .memoryena (memoryena),
      .block1ena (d_block1ena),
      .block1wea (d_block1wea),
      .block2ena (d_block2ena),
      .block2wea (d_block2wea),
      .seriena   (d_seriena),
      .deseriena (d_deseriena),
      .addr      (d_addr),
      .done      (d_done)
   );

   // Clock / reset defaults
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One rising edge, then settle 1 ns so outputs are sampled away from it.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      memoryena = 2'b11;
      tick(2);
      tests_run++;
      if (en !== EN_IDLE || addr !== 2'd0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_narrow: en=%b addr=%0d done=%b, want en=%b addr=0 done=0",
                  en, addr, done, EN_IDLE);
      end
      tests_run++;
      if (d_en !== EN_IDLE || d_addr !== 10'd0 || d_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_wide: en=%b addr=%0d done=%b, want en=%b addr=0 done=0",
                  d_en, d_addr, d_done, EN_IDLE);
      end
      reset     = 1'b0;
      memoryena = 2'b00;
      tick(1);
      tests_run++;
      if (en !== EN_IDLE || addr !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_release_idle: en=%b addr=%0d, want en=%b addr=0",
                  en, addr, EN_IDLE);
      end
   endtask

   task automatic test_mode_sweep();
      logic [1:0] modes [4];
      logic [5:0] exp_en[4];
      modes  = '{2'b00, 2'b01, 2'b10, 2'b11};
      exp_en = '{EN_IDLE, EN_FILL1, EN_FILL2, EN_DRN2};
      for (int m = 0; m < 4; m++) begin
         memoryena = modes[m];
         tick(1);
         tests_run++;
         if (en !== exp_en[m] || addr !== 2'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL sweep_mode%0d: en=%b addr=%0d done=%b, want en=%b addr=0 done=0",
                     m, en, addr, done, exp_en[m]);
         end
         tick(9);
         tests_run++;
         if (en !== exp_en[m] || d_en !== exp_en[m]) begin
            tests_failed++;
            $display("FAIL sweep_hold%0d: en=%b wide_en=%b, want %b",
                     m, en, d_en, exp_en[m]);
         end
      end
      // Ten cycles of held drain on the wide instance: 0..9
      tests_run++;
      if (d_addr !== 10'd9) begin
         tests_failed++;
         $display("FAIL sweep_wide_addr: got %0d want 9", d_addr);
      end
   endtask

   task automatic test_ping_pong();
      memoryena = 2'b01;
      tick(4);
      tests_run++;
      if (en !== EN_FILL1 || addr !== 2'd3) begin
         tests_failed++;
         $display("FAIL pp_fill1: en=%b addr=%0d, want en=%b addr=3", en, addr, EN_FILL1);
      end
      memoryena = 2'b00;
      tick(1);
      memoryena = 2'b11;
      tick(1);
      tests_run++;
      if (en !== EN_DRN1) begin
         tests_failed++;
         $display("FAIL pp_drain_after_idle: got %b want %b", en, EN_DRN1);
      end
      memoryena = 2'b10;
      tick(2);
      memoryena = 2'b11;
      tick(1);
      tests_run++;
      if (en !== EN_DRN2) begin
         tests_failed++;
         $display("FAIL pp_fill2_to_drain: got %b want %b", en, EN_DRN2);
      end
      memoryena = 2'b01;
      tick(2);
      memoryena = 2'b11;
      tick(1);
      tests_run++;
      if (en !== EN_DRN1) begin
         tests_failed++;
         $display("FAIL pp_fill1_to_drain: got %b want %b", en, EN_DRN1);
      end
   endtask

   task automatic test_addr_wrap();
      logic [1:0] exp_a[6];
      logic       exp_d[6];
      exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      memoryena = 2'b00;
      tick(1);
      memoryena = 2'b01;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         tests_run++;
         if (addr !== exp_a[i] || done !== exp_d[i]) begin
            tests_failed++;
            $display("FAIL wrap_cycle%0d: addr=%0d done=%b, want addr=%0d done=%b",
                     i, addr, done, exp_a[i], exp_d[i]);
         end
         tests_run++;
         if (d_addr !== 10'(i) || d_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_wide_cycle%0d: addr=%0d done=%b, want addr=%0d done=0",
                     i, d_addr, d_done, i);
         end
      end
   endtask

   task automatic test_mode_change_addr();
      memoryena = 2'b00;
      tick(1);
      memoryena = 2'b01;
      tick(3);
      tests_run++;
      if (addr !== 2'd2) begin
         tests_failed++;
         $display("FAIL chg_pre_addr: got %0d want 2", addr);
      end
      memoryena = 2'b10;
      tick(1);
      tests_run++;
      if (addr !== 2'd0 || done !== 1'b0 || en !== EN_FILL2) begin
         tests_failed++;
         $display("FAIL chg_fill1_to_fill2: addr=%0d done=%b en=%b, want addr=0 done=0 en=%b",
                  addr, done, en, EN_FILL2);
      end
      // Change mode exactly when addr is all ones: no done pulse.
      tick(3);
      tests_run++;
      if (addr !== 2'd3) begin
         tests_failed++;
         $display("FAIL chg_at_max_pre: got %0d want 3", addr);
      end
      memoryena = 2'b11;
      tick(1);
      tests_run++;
      if (addr !== 2'd0 || done !== 1'b0 || en !== EN_DRN2) begin
         tests_failed++;
         $display("FAIL chg_at_max: addr=%0d done=%b en=%b, want addr=0 done=0 en=%b",
                  addr, done, en, EN_DRN2);
      end
   endtask

   task automatic test_reset_mid_fill();
      memoryena = 2'b10;
      tick(2);
      reset = 1'b1;
      tick(1);
      tests_run++;
      if (en !== EN_IDLE || addr !== 2'd0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL midfill_reset: en=%b addr=%0d done=%b, want all 0", en, addr, done);
      end
      reset     = 1'b0;
      memoryena = 2'b11;
      tick(1);
      tests_run++;
      if (en !== EN_DRN1 || addr !== 2'd0) begin
         tests_failed++;
         $display("FAIL midfill_drain: en=%b addr=%0d, want en=%b addr=0", en, addr, EN_DRN1);
      end
      // Reset on the edge that would have ended a block-2 fill.
      memoryena = 2'b10;
      tick(2);
      reset     = 1'b1;
      memoryena = 2'b00;
      tick(1);
      reset     = 1'b0;
      memoryena = 2'b11;
      tick(1);
      tests_run++;
      if (en !== EN_DRN1) begin
         tests_failed++;
         $display("FAIL reset_discards_sel: got %b want %b", en, EN_DRN1);
      end
   endtask

   task automatic test_back_to_back();
      // Drain held across a wrap on the narrow instance: done pulses once.
      memoryena = 2'b00;
      tick(1);
      memoryena = 2'b11;
      tick(4);
      tests_run++;
      if (addr !== 2'd3 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_pre_wrap: addr=%0d done=%b, want addr=3 done=0", addr, done);
      end
      tick(1);
      tests_run++;
      if (addr !== 2'd0 || done !== 1'b1 || en !== EN_DRN1) begin
         tests_failed++;
         $display("FAIL b2b_wrap: addr=%0d done=%b en=%b, want addr=0 done=1 en=%b",
                  addr, done, en, EN_DRN1);
      end
      tick(1);
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_done_clear: got %b want 0", done);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      memoryena    = 2'b00;
      #2;
      test_reset();
      test_mode_sweep();
      test_ping_pong();
      test_addr_wrap();
      test_mode_change_addr();
      test_reset_mid_fill();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
